// File: rtl/decoder_fetch_seq.sv
// 6502 instruction decoder with 0-2 operand-byte fetch sequencer and registered valid/ready op output.
// Optional: define DECODER_ILLEGAL_TRAP_EN to halt byte intake after an illegal opcode until reset.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef OPP_WIDTH
`define OPP_WIDTH 5
`endif

module decoder_fetch_seq #(
    parameter int REG_WIDTH  = `REG_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int OPP_WIDTH  = `OPP_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_WIDTH-1:0]   byte_in,
    input  logic [ADDR_WIDTH-1:0]  byte_addr,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic [7:0]             opcode,
    output logic [OPP_WIDTH-1:0]   opp,
    output logic [3:0]             mode,
    output logic [2*REG_WIDTH-1:0] operand,
    output logic [1:0]             op_len,
    output logic [ADDR_WIDTH-1:0]  op_pc,
    output logic                   illegal
);
    typedef enum logic [1:0] {FETCH_OP, FETCH_LO, FETCH_HI, TRAP} state_t;
    typedef enum logic [3:0] {
        M_IMP = 4'd0, M_ACC = 4'd1, M_IMM = 4'd2, M_ZP = 4'd3, M_ZPX = 4'd4,
        M_ZPY = 4'd5, M_ABS = 4'd6, M_ABSX = 4'd7, M_ABSY = 4'd8, M_INDX = 4'd9,
        M_INDY = 4'd10, M_REL = 4'd11, M_IND = 4'd12
    } mode_t;

    state_t state, state_next;
    logic   xfer, load;

    logic [2:0] aaa, bbb;
    logic [1:0] cc;
    mode_t      dec_mode;
    logic       dec_ill;
    logic [1:0] dec_len;

    logic [7:0]            cur_opcode;
    logic [ADDR_WIDTH-1:0] cur_pc;
    mode_t                 cur_mode;
    logic [1:0]            cur_len;
    logic                  cur_ill;
    logic [REG_WIDTH-1:0]  cur_lo;

    logic [7:0]             ld_opcode;
    mode_t                  ld_mode;
    logic [1:0]             ld_len;
    logic [ADDR_WIDTH-1:0]  ld_pc;
    logic                   ld_ill;
    logic [2*REG_WIDTH-1:0] ld_operand;

    assign byte_ready = !reset && (state != TRAP) && (!op_valid || op_ready);
    assign xfer       = byte_valid && byte_ready;

    always_comb begin
        aaa      = byte_in[7:5];
        bbb      = byte_in[4:2];
        cc       = byte_in[1:0];
        dec_mode = M_IMP;
        dec_ill  = 1'b0;
        case (cc)
            2'b01: begin
                case (bbb)
                    3'd0: dec_mode = M_INDX;
                    3'd1: dec_mode = M_ZP;
                    3'd2: dec_mode = M_IMM;
                    3'd3: dec_mode = M_ABS;
                    3'd4: dec_mode = M_INDY;
                    3'd5: dec_mode = M_ZPX;
                    3'd6: dec_mode = M_ABSY;
                    default: dec_mode = M_ABSX;
                endcase
            end
            2'b10: begin
                case (bbb)
                    3'd0: if (aaa == 3'b101) dec_mode = M_IMM; else dec_ill = 1'b1;
                    3'd1: dec_mode = M_ZP;
                    3'd2: dec_mode = M_ACC;
                    3'd3: dec_mode = M_ABS;
                    3'd4: dec_ill = 1'b1;
                    3'd5: dec_mode = (aaa == 3'b100 || aaa == 3'b101) ? M_ZPY : M_ZPX;
                    3'd6: dec_mode = M_IMP;
                    default: dec_mode = (aaa == 3'b101) ? M_ABSY : M_ABSX;
                endcase
            end
            2'b00: begin
                case (bbb)
                    3'd0: begin
                        case (aaa)
                            3'b001:                dec_mode = M_ABS;
                            3'b100:                dec_ill  = 1'b1;
                            3'b101, 3'b110, 3'b111: dec_mode = M_IMM;
                            default:               dec_mode = M_IMP;
                        endcase
                    end
                    3'd1: dec_mode = M_ZP;
                    3'd2: dec_mode = M_IMP;
                    3'd3: dec_mode = (aaa == 3'b011) ? M_IND : M_ABS;
                    3'd4: dec_mode = M_REL;
                    3'd5: dec_mode = M_ZPX;
                    3'd6: dec_mode = M_IMP;
                    default: dec_mode = M_ABSX;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) dec_mode = M_IMP;
        case (dec_mode)
            M_IMP, M_ACC:                dec_len = 2'd1;
            M_ABS, M_ABSX, M_ABSY, M_IND: dec_len = 2'd3;
            default:                     dec_len = 2'd2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH_OP;
        else       state <= state_next;
    end

    // Output fields come straight from the decoder for 1-byte ops, otherwise from the latched opcode.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        ld_opcode  = cur_opcode;
        ld_mode    = cur_mode;
        ld_len     = cur_len;
        ld_pc      = cur_pc;
        ld_ill     = cur_ill;
        ld_operand = '0;
        case (state)
            FETCH_OP: begin
                ld_opcode = byte_in[7:0];
                ld_mode   = dec_mode;
                ld_len    = dec_len;
                ld_pc     = byte_addr;
                ld_ill    = dec_ill;
                if (xfer) begin
                    if (dec_len != 2'd1) begin
                        state_next = FETCH_LO;
                    end else begin
                        load = 1'b1;
`ifdef DECODER_ILLEGAL_TRAP_EN
                        if (dec_ill) state_next = TRAP;
`endif
                    end
                end
            end
            FETCH_LO: begin
                ld_operand = {{REG_WIDTH{1'b0}}, byte_in};
                if (xfer) begin
                    if (cur_len == 2'd3) begin
                        state_next = FETCH_HI;
                    end else begin
                        load       = 1'b1;
                        state_next = FETCH_OP;
                    end
                end
            end
            FETCH_HI: begin
                ld_operand = {byte_in, cur_lo};
                if (xfer) begin
                    load       = 1'b1;
                    state_next = FETCH_OP;
                end
            end
            default: begin
`ifdef DECODER_ILLEGAL_TRAP_EN
                state_next = TRAP;
`else
                state_next = FETCH_OP;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_valid   <= 1'b0;
            opcode     <= '0;
            opp        <= '0;
            mode       <= '0;
            operand    <= '0;
            op_len     <= '0;
            op_pc      <= '0;
            illegal    <= 1'b0;
            cur_opcode <= '0;
            cur_pc     <= '0;
            cur_mode   <= M_IMP;
            cur_len    <= '0;
            cur_ill    <= 1'b0;
            cur_lo     <= '0;
        end else begin
            if (op_valid && op_ready) op_valid <= 1'b0;
            if (xfer && state == FETCH_OP) begin
                cur_opcode <= byte_in[7:0];
                cur_pc     <= byte_addr;
                cur_mode   <= dec_mode;
                cur_len    <= dec_len;
                cur_ill    <= dec_ill;
            end
            if (xfer && state == FETCH_LO) cur_lo <= byte_in;
            if (load) begin
                op_valid <= 1'b1;
                opcode   <= ld_opcode;
                opp      <= OPP_WIDTH'({ld_opcode[7:5], ld_opcode[1:0]});
                mode     <= ld_mode;
                operand  <= ld_operand;
                op_len   <= ld_len;
                op_pc    <= ld_pc;
                illegal  <= ld_ill;
            end
        end
    end
endmodule

// File: tb/tb_decoder_fetch_seq.sv
// Scoreboard bench for decoder_fetch_seq: directed byte streams, monitor pops expected ops on each handshake.
module tb_decoder_fetch_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic [15:0] byte_addr;
    logic        byte_valid;
    logic        byte_ready;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  opcode;
    logic [4:0]  opp;
    logic [3:0]  mode;
    logic [15:0] operand;
    logic [1:0]  op_len;
    logic [15:0] op_pc;
    logic        illegal;

    decoder_fetch_seq #(.REG_WIDTH(8), .ADDR_WIDTH(16), .OPP_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_addr(byte_addr),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .op_valid(op_valid),
        .op_ready(op_ready), .opcode(opcode), .opp(opp), .mode(mode),
        .operand(operand), .op_len(op_len), .op_pc(op_pc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  opc;
        logic [4:0]  opp;
        logic [3:0]  mode;
        logic [15:0] operand;
        logic [1:0]  len;
        logic [15:0] pc;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   pop_last = 0;
    int   pop_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_op(input logic [7:0] opc, input logic [4:0] p, input logic [3:0] m,
                             input logic [15:0] opd, input logic [1:0] len, input logic [15:0] pc,
                             input logic ill);
        exp_t e;
        e.opc = opc; e.opp = p; e.mode = m; e.operand = opd; e.len = len; e.pc = pc; e.ill = ill;
        sb.push_back(e);
    endtask

    // Monitor: inputs only change on negedge, so sample 2 time units later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && op_valid && op_ready) begin
                pop_prev = pop_last;
                pop_last = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_op", {56'd0, opcode}, 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("op_%02h", e.opc),
                          {7'd0, opcode, opp, mode, operand, op_len, op_pc, illegal},
                          {7'd0, e.opc, e.opp, e.mode, e.operand, e.len, e.pc, e.ill});
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic [15:0] a, output int waits);
        waits = 0;
        byte_in = b; byte_addr = a; byte_valid = 1'b1;
        #1;
        while (!byte_ready && waits < 50) begin
            @(negedge clk); #1; waits++;
        end
        if (!byte_ready) check($sformatf("byte_timeout_%02h", b), 64'd0, 64'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int w;
        reset = 1'b1; byte_valid = 1'b0; byte_in = '0; byte_addr = '0; op_ready = 1'b1;
        idle(2);
        #1;
        check("reset_outputs",
              {19'd0, byte_ready, op_valid, opcode, opp, mode, operand, op_len, op_pc, illegal}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // LDA #imm
        expect_op(8'hA9, 5'b10101, 4'd2, 16'h0042, 2'd2, 16'h0200, 1'b0);
        send(8'hA9, 16'h0200, w); send(8'h42, 16'h0201, w);
        idle(2);
        // STA abs, JMP (ind)
        expect_op(8'h8D, 5'b10001, 4'd6, 16'h3000, 2'd3, 16'h0210, 1'b0);
        send(8'h8D, 16'h0210, w); send(8'h00, 16'h0211, w); send(8'h30, 16'h0212, w);
        expect_op(8'h6C, 5'b01100, 4'd12, 16'h1234, 2'd3, 16'h0213, 1'b0);
        send(8'h6C, 16'h0213, w); send(8'h34, 16'h0214, w); send(8'h12, 16'h0215, w);
        idle(2);
        // LDX zp,Y and BPL rel
        expect_op(8'hB6, 5'b10110, 4'd5, 16'h0080, 2'd2, 16'h0220, 1'b0);
        send(8'hB6, 16'h0220, w); send(8'h80, 16'h0221, w);
        expect_op(8'h10, 5'b00000, 4'd11, 16'h00FE, 2'd2, 16'h0222, 1'b0);
        send(8'h10, 16'h0222, w); send(8'hFE, 16'h0223, w);
        idle(2);

        // Back-to-back 1-byte ops
        expect_op(8'h0A, 5'b00010, 4'd1, 16'h0000, 2'd1, 16'h0230, 1'b0);
        expect_op(8'hE8, 5'b11100, 4'd0, 16'h0000, 2'd1, 16'h0231, 1'b0);
        send(8'h0A, 16'h0230, w); send(8'hE8, 16'h0231, w);
        @(negedge clk); #3;
        check("b2b_pop_gap", 64'(pop_last - pop_prev), 64'd1);
        idle(2);

        // Backpressure
        op_ready = 1'b0;
        expect_op(8'hC8, 5'b11000, 4'd0, 16'h0000, 2'd1, 16'h0400, 1'b0);
        expect_op(8'hEA, 5'b11110, 4'd1, 16'h0000, 2'd1, 16'h0401, 1'b0);
        send(8'hC8, 16'h0400, w);
        for (int i = 0; i < 3; i++) begin
            byte_in = 8'hEA; byte_addr = 16'h0401; byte_valid = 1'b1;
            #1;
            check($sformatf("stall_%0d", i), {38'd0, byte_ready, op_valid, opcode, op_pc},
                  {38'd0, 1'b0, 1'b1, 8'hC8, 16'h0400});
            @(negedge clk);
        end
        op_ready = 1'b1;
        send(8'hEA, 16'h0401, w);
        check("stall_release_waits", 64'(w), 64'd0);
        idle(2);

        // Reset mid-fetch discards the partial LDA abs
        send(8'hAD, 16'h0300, w); send(8'h00, 16'h0301, w);
        reset = 1'b1;
        #1;
        check("midreset_outputs", {62'd0, byte_ready, op_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        expect_op(8'hE8, 5'b11100, 4'd0, 16'h0000, 2'd1, 16'h0310, 1'b0);
        send(8'hE8, 16'h0310, w);
        idle(2);

        // Illegal opcode
        expect_op(8'h02, 5'b00010, 4'd0, 16'h0000, 2'd1, 16'h0500, 1'b1);
`ifdef DECODER_ILLEGAL_TRAP_EN
        send(8'h02, 16'h0500, w);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            byte_in = 8'hEA; byte_addr = 16'h0501; byte_valid = 1'b1;
            #1;
            check($sformatf("trap_%0d", i), {62'd0, byte_ready, op_valid}, 64'd0);
            @(negedge clk);
        end
        byte_valid = 1'b0;
`else
        expect_op(8'hEA, 5'b11110, 4'd1, 16'h0000, 2'd1, 16'h0501, 1'b0);
        send(8'h02, 16'h0500, w); send(8'hEA, 16'h0501, w);
`endif

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        idle(2);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end
endmodule
